memwb_pipe_reg: RTL and testbench
=================================

# memwb_pipe_reg

Parametrised MEM/WB pipeline stage register with valid/ready flow control, a two-entry skid buffer, synchronous flush and a built-in write-back select. It sits between the data-memory stage and the register file. It holds the ALU result, the memory read word, the destination register and the WB control bits. It drives the register-file write port directly. Unlike a plain stage register, it absorbs downstream stalls without losing data and without a combinational ready path.

## Interface
Parameters:
- DATA_W, 32, width of ALU result, memory read word and write-back data
- ADDR_W, 5, width of destination register index

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; registered, not a combinational function of out_ready
- in_alu_res  in  DATA_W  ALU result
- in_read_data  in  DATA_W  memory read word
- in_rd  in  ADDR_W  destination register
- in_mem_to_reg  in  1  1 = write back memory word, 0 = ALU result
- in_reg_write  in  1  entry writes the register file
- flush  in  1  discard all held and incoming entries this cycle
- out_valid  out  1  head entry present
- out_ready  in  1  downstream (WB) accepts head
- out_alu_res, out_read_data  out  DATA_W  head fields
- out_rd  out  ADDR_W  head destination
- out_mem_to_reg, out_reg_write  out  1  head WB controls
- wb_data  out  DATA_W  out_mem_to_reg ? out_read_data : out_alu_res (combinational from head)
- wb_en  out  1  out_valid & out_ready & out_reg_write & (out_rd != 0)
- occupancy  out  2  entries held, 0..2

## Operation
- Storage: a head register (H) and a skid register (S), each with a valid bit. Outputs are driven from H only.
- Accept: in_fire = in_valid & in_ready & !flush. Drain: out_fire = out_valid & out_ready.
- Per-edge rules, with flush low:
  - H empty, or out_fire with S empty: H <= input if in_fire, otherwise H becomes invalid.
  - out_fire with S full: H <= S. S <= input if in_fire, otherwise S becomes invalid.
  - H full, no out_fire, in_fire: S <= input. An accept with S already full cannot occur because in_ready is 0.
- in_ready next = !(S valid next). It is registered, and goes to 1 on the edge where S empties.
- Flush: both valid bits clear on the edge. The input that cycle is ignored. Data fields may keep stale values, but every valid-qualified output reads as idle. Flush overrides out_fire.
- wb_en is forced to 0 for out_rd == 0, because register x0 is hardwired.
- Data fields load only when their entry is written. There is no bubble toggling of data when valid is 0.
- Reset: H and S invalid, in_ready = 1, out_valid = 0, occupancy = 0, wb_en = 0. All data and control outputs are 0.

## Timing
- Latency: 1 cycle from in_fire to out_valid when H is empty or drains in the same cycle.
- Throughput: 1 entry/cycle while out_ready is held at 1. S is never used in that case.
- Stall absorption: when out_ready drops, the entry in flight lands in S. in_ready falls on the next edge. No entry is lost or duplicated.
- Resume: the first out_fire moves S to H. in_ready rises on that same edge.
- Simultaneous in_fire and out_fire with S empty: the new entry replaces H, and occupancy is unchanged.
- Simultaneous flush and in_valid: the entry is dropped, occupancy becomes 0, and in_ready becomes 1.
- rst_n asserted mid-transfer: the state clears immediately and asynchronously. The first accept is possible on the first edge after rst_n deasserts.
- occupancy is {H valid + S valid}, registered.

## Test plan
- Reset then stream: after rst_n deasserts, apply 4 entries back-to-back (alu 0x10..0x13, rd 1..4, reg_write 1, mem_to_reg 0) with out_ready=1. Required: out_valid one cycle after each accept, wb_data 0x10..0x13 in order, wb_en=1 each cycle, occupancy stays 1.
- Stall/skid: stream entries A, B, C and drop out_ready for 3 cycles after A appears. Required: B is held in S, occupancy=2, in_ready=0 the next cycle, C is held upstream. On resume the order is A, B, C with no loss or duplicates.
- Mem select and x0: entry with mem_to_reg=1, read_data=0xDEADBEEF, rd=7 gives wb_data=0xDEADBEEF and wb_en=1. The same entry with rd=0 gives wb_en=0 while out_valid=1.
- Flush with full buffer: occupancy=2 and in_valid=1 with flush=1 for one cycle. Required next cycle: out_valid=0, occupancy=0, in_ready=1. The flushed input never appears at the output.
- Async reset mid-stall: assert rst_n=0 between clock edges while occupancy=2. Required: out_valid=0, occupancy=0 and all outputs 0 immediately, before the next edge. in_ready=1.
- Width parameter: build with DATA_W=64 and ADDR_W=6 and stream alu 0xFFFF_FFFF_0000_0001 to rd 63. Required: wb_data is that full value with no truncation, and wb_en=1.

Source files
------------

// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline stage register with a two-entry skid buffer, synchronous
// flush and the write-back data select feeding the register-file write port.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is registered, so it never depends on out_ready in the same
// cycle. out_valid/out_* come straight from the head register, and they stay
// stable while out_valid is high and out_ready is low.
module memwb_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_alu_res,
   input  logic [DATA_W-1:0] in_read_data,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic              in_mem_to_reg,
   input  logic              in_reg_write,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_alu_res,
   output logic [DATA_W-1:0] out_read_data,
   output logic [ADDR_W-1:0] out_rd,
   output logic              out_mem_to_reg,
   output logic              out_reg_write,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_en,
   output logic [1:0]        occupancy
);

   // An entry is packed as {alu_res, read_data, rd, mem_to_reg, reg_write}.
   localparam int EW = 2*DATA_W + ADDR_W + 2;

   logic [EW-1:0] in_entry;
   logic [EW-1:0] h_q;
   logic [EW-1:0] s_q;
   logic          h_valid_q;
   logic          s_valid_q;
   logic          in_ready_q;
   logic [1:0]    occ_q;

   logic          in_fire;
   logic          out_fire;
   logic          h_load_in;
   logic          h_load_s;
   logic          s_load_in;
   logic          h_valid_d;
   logic          s_valid_d;

   assign in_entry = {in_alu_res, in_read_data, in_rd, in_mem_to_reg, in_reg_write};
   assign in_fire  = in_valid & in_ready_q & ~flush;
   assign out_fire = h_valid_q & out_ready;

   // Next-state selection for head and skid; flush wins over any transfer.
   always_comb begin
      h_load_in = 1'b0;
      h_load_s  = 1'b0;
      s_load_in = 1'b0;
      h_valid_d = h_valid_q;
      s_valid_d = s_valid_q;
      if (flush) begin
         h_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (!h_valid_q || (out_fire && !s_valid_q)) begin
         // Head is free this edge: take the input directly (pass-through path).
         h_load_in = in_fire;
         h_valid_d = in_fire;
      end else if (out_fire) begin
         // Head drains and the skid entry moves up; the skid refills from input.
         h_load_s  = 1'b1;
         h_valid_d = 1'b1;
         s_load_in = in_fire;
         s_valid_d = in_fire;
      end else if (in_fire) begin
         // Head is stalled: the in-flight entry lands in the skid register.
         s_load_in = 1'b1;
         s_valid_d = 1'b1;
      end
   end

   // Valid bits, registered ready and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_valid_q  <= 1'b0;
         s_valid_q  <= 1'b0;
         in_ready_q <= 1'b1;
         occ_q      <= 2'd0;
      end else begin
         h_valid_q  <= h_valid_d;
         s_valid_q  <= s_valid_d;
         in_ready_q <= ~s_valid_d;
         occ_q      <= {1'b0, h_valid_d} + {1'b0, s_valid_d};
      end
   end

   // Entry payloads load only when their slot is written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q <= '0;
         s_q <= '0;
      end else begin
         if (h_load_in) begin
            h_q <= in_entry;
         end else if (h_load_s) begin
            h_q <= s_q;
         end
         if (s_load_in) begin
            s_q <= in_entry;
         end
      end
   end

   assign {out_alu_res, out_read_data, out_rd, out_mem_to_reg, out_reg_write} = h_q;

   assign out_valid = h_valid_q;
   assign in_ready  = in_ready_q;
   assign occupancy = occ_q;
   assign wb_data   = out_mem_to_reg ? out_read_data : out_alu_res;
   // Register x0 is hardwired to zero, so writes to it are suppressed.
   assign wb_en     = out_valid & out_ready & out_reg_write & (out_rd != '0);

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Directed bench for memwb_pipe_reg: default-width instance plus a 64-bit
// instance for the width check. A monitor records every output transfer of the
// default instance against an expected queue of ALU results.
module tb_memwb_pipe_reg;

   logic clk;
   logic rst_n;

   // Default-width DUT signals
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_alu_res, in_read_data, out_alu_res, out_read_data, wb_data;
   logic [4:0]  in_rd, out_rd;
   logic        in_mem_to_reg, in_reg_write, out_mem_to_reg, out_reg_write, wb_en;
   logic [1:0]  occupancy;

   // Wide DUT signals
   logic        w_in_valid, w_in_ready, w_flush, w_out_valid, w_out_ready;
   logic [63:0] w_in_alu_res, w_in_read_data, w_out_alu_res, w_out_read_data, w_wb_data;
   logic [5:0]  w_in_rd, w_out_rd;
   logic        w_in_mem_to_reg, w_in_reg_write, w_out_mem_to_reg, w_out_reg_write, w_wb_en;
   logic [1:0]  w_occupancy;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   memwb_pipe_reg #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_res(in_alu_res), .in_read_data(in_read_data), .in_rd(in_rd),
      .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_alu_res(out_alu_res), .out_read_data(out_read_data), .out_rd(out_rd),
      .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
      .wb_data(wb_data), .wb_en(wb_en), .occupancy(occupancy)
   );

   memwb_pipe_reg #(.DATA_W(64), .ADDR_W(6)) dut_w (
      .clk(clk), .rst_n(rst_n),
      .in_valid(w_in_valid), .in_ready(w_in_ready),
      .in_alu_res(w_in_alu_res), .in_read_data(w_in_read_data), .in_rd(w_in_rd),
      .in_mem_to_reg(w_in_mem_to_reg), .in_reg_write(w_in_reg_write),
      .flush(w_flush),
      .out_valid(w_out_valid), .out_ready(w_out_ready),
      .out_alu_res(w_out_alu_res), .out_read_data(w_out_read_data), .out_rd(w_out_rd),
      .out_mem_to_reg(w_out_mem_to_reg), .out_reg_write(w_out_reg_write),
      .wb_data(w_wb_data), .wb_en(w_wb_en), .occupancy(w_occupancy)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [4:0] rd, input logic m2r, input logic rw);
      in_valid      = v;
      in_alu_res    = alu;
      in_read_data  = rdata;
      in_rd         = rd;
      in_mem_to_reg = m2r;
      in_reg_write  = rw;
   endtask

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Output transfer monitor for the default-width instance.
   always @(posedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_fire", out_alu_res, 64'hFFFF_FFFF);
         else                   check("fire_order", out_alu_res, exp_q.pop_front());
      end
   end

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      w_in_valid = 1'b0; w_in_alu_res = '0; w_in_read_data = '0; w_in_rd = '0;
      w_in_mem_to_reg = 1'b0; w_in_reg_write = 1'b0; w_flush = 1'b0; w_out_ready = 1'b0;

      // Reset values
      step();
      step();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_occ", occupancy, 0);
      check("rst_wb_en", wb_en, 0);
      check("rst_wb_data", wb_data, 0);
      rst_n = 1'b1;
      step();

      // Back-to-back stream with out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(32'h10 + 32'(i));
         drive(1'b1, 32'h10 + 32'(i), 32'h0, 5'(i + 1), 1'b0, 1'b1);
         step();
         check("stream_valid", out_valid, 1);
         check("stream_wb_data", wb_data, 64'h10 + 64'(i));
         check("stream_wb_en", wb_en, 1);
         check("stream_occ", occupancy, 1);
      end
      drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      step();
      check("stream_drain_valid", out_valid, 0);
      check("stream_drain_occ", occupancy, 0);

      // Stall/skid: A, B, C with out_ready low for three edges after A lands
      exp_q.push_back(32'hA0);
      exp_q.push_back(32'hB0);
      exp_q.push_back(32'hC0);
      drive(1'b1, 32'hA0, 32'h0, 5'd5, 1'b0, 1'b1);
      step();
      check("skid_a_head", out_alu_res, 32'hA0);
      out_ready = 1'b0;
      drive(1'b1, 32'hB0, 32'h0, 5'd6, 1'b0, 1'b1);
      step();
      check("skid_occ2", occupancy, 2);
      check("skid_in_ready0", in_ready, 0);
      check("skid_head_held", out_alu_res, 32'hA0);
      check("skid_wb_en_stall", wb_en, 0);
      drive(1'b1, 32'hC0, 32'h0, 5'd8, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         step();
         check("skid_hold_occ", occupancy, 2);
         check("skid_hold_ready", in_ready, 0);
         check("skid_hold_head", out_alu_res, 32'hA0);
      end
      out_ready = 1'b1;
      step();
      check("resume_head_b", out_alu_res, 32'hB0);
      check("resume_occ", occupancy, 1);
      check("resume_in_ready", in_ready, 1);
      step();
      check("resume_head_c", out_alu_res, 32'hC0);
      check("resume_occ_c", occupancy, 1);
      drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      step();
      check("skid_empty", out_valid, 0);

      // Memory select and x0 suppression
      exp_q.push_back(32'h55);
      exp_q.push_back(32'h55);
      drive(1'b1, 32'h55, 32'hDEADBEEF, 5'd7, 1'b1, 1'b1);
      step();
      check("mem_wb_data", wb_data, 32'hDEADBEEF);
      check("mem_wb_en", wb_en, 1);
      check("mem_rd", out_rd, 7);
      drive(1'b1, 32'h55, 32'hDEADBEEF, 5'd0, 1'b1, 1'b1);
      step();
      check("x0_valid", out_valid, 1);
      check("x0_wb_en", wb_en, 0);
      check("x0_wb_data", wb_data, 32'hDEADBEEF);
      drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      step();
      check("x0_drain_occ", occupancy, 0);

      // Flush with both slots full and a new input offered
      out_ready = 1'b0;
      drive(1'b1, 32'hD0, 32'h0, 5'd3, 1'b0, 1'b1);
      step();
      drive(1'b1, 32'hE0, 32'h0, 5'd4, 1'b0, 1'b1);
      step();
      check("flush_pre_occ", occupancy, 2);
      drive(1'b1, 32'hF0, 32'h0, 5'd9, 1'b0, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_valid", out_valid, 0);
      check("flush_occ", occupancy, 0);
      check("flush_in_ready", in_ready, 1);
      drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      out_ready = 1'b1;
      step();
      step();
      check("flush_no_ghost", out_valid, 0);

      // Asynchronous reset while both slots are full
      out_ready = 1'b0;
      drive(1'b1, 32'h61, 32'h62, 5'd11, 1'b1, 1'b1);
      step();
      drive(1'b1, 32'h71, 32'h72, 5'd12, 1'b0, 1'b1);
      step();
      check("areset_pre_occ", occupancy, 2);
      drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      check("areset_valid", out_valid, 0);
      check("areset_occ", occupancy, 0);
      check("areset_in_ready", in_ready, 1);
      check("areset_alu", out_alu_res, 0);
      check("areset_read_data", out_read_data, 0);
      check("areset_rd", out_rd, 0);
      check("areset_ctrl", {out_mem_to_reg, out_reg_write}, 0);
      check("areset_wb_data", wb_data, 0);
      #1 rst_n = 1'b1;
      exp_q.push_back(32'h77);
      out_ready = 1'b1;
      drive(1'b1, 32'h77, 32'h0, 5'd9, 1'b0, 1'b1);
      step();
      check("post_reset_accept", out_valid, 1);
      check("post_reset_alu", out_alu_res, 32'h77);
      drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      step();

      // 64-bit data / 6-bit index instance
      w_out_ready = 1'b1;
      w_in_valid = 1'b1;
      w_in_alu_res = 64'hFFFF_FFFF_0000_0001;
      w_in_read_data = 64'h0;
      w_in_rd = 6'd63;
      w_in_mem_to_reg = 1'b0;
      w_in_reg_write = 1'b1;
      step();
      check("wide_wb_data", w_wb_data, 64'hFFFF_FFFF_0000_0001);
      check("wide_wb_en", w_wb_en, 1);
      check("wide_rd", w_out_rd, 63);
      w_in_valid = 1'b0;
      step();
      check("wide_drain", w_out_valid, 0);

      check("exp_q_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
